window3x3: RTL



---
 rtl/window3x3_if.sv | 30 +++
 rtl/window3x3.sv | 102 ++++++++++
 2 files changed

// File: rtl/window3x3_if.sv
// Pixel-stream in / 3x3-window out bundle for window3x3.
// The slave modport is the window generator; the master modport is the pixel source and window consumer.
interface window3x3_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  win_valid;
  logic                  frame_done;
  logic [DATA_WIDTH-1:0] _1, _2, _3, _4, _5, _6, _7, _8, _9;
  logic [CW-1:0]         cx;
  logic [RW-1:0]         cy;

  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, frame_done, _1, _2, _3, _4, _5, _6, _7, _8, _9, cx, cy
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, frame_done, _1, _2, _3, _4, _5, _6, _7, _8, _9, cx, cy
  );
endinterface

// File: rtl/window3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting 3x3 register array.
// One-cycle latency from accepted pixel to window; no backpressure, idle cycles hold all state.
module window3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic          clk,
  input  logic          rst,
  window3x3_if.slave    bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win [9];
  logic                  r_win_vld;
  logic                  r_frame_done;
  logic [CW-1:0]         r_cx;
  logic [RW-1:0]         r_cy;

  logic [CW-1:0]         w_col;
  logic [RW-1:0]         w_row;
  logic [DATA_WIDTH-1:0] w_lb0_q;
  logic [DATA_WIDTH-1:0] w_lb1_q;
  logic                  w_emit;
  logic                  w_last;

  // A start-of-frame pixel is position (0,0) no matter where the counters are.
  assign w_col   = bus.in_sof ? '0 : r_col;
  assign w_row   = bus.in_sof ? '0 : r_row;
  assign w_lb0_q = r_lb0[w_col];
  assign w_lb1_q = r_lb1[w_col];
  assign w_emit  = bus.in_valid && (w_col >= CW'(2)) && (w_row >= RW'(2));
  assign w_last  = (w_col == LAST_COL) && (w_row == LAST_ROW);

  // Column-addressed line RAMs: read old (col,row-1)/(col,row-2), then overwrite.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      r_lb0[w_col] <= bus.in_data;
      r_lb1[w_col] <= w_lb0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      r_cx         <= '0;
      r_cy         <= '0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      r_win_vld    <= 1'b0;
      r_frame_done <= 1'b0;
      if (bus.in_valid) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_lb1_q;
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_lb0_q;
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= bus.in_data;
        if (w_col == LAST_COL) begin
          r_col <= '0;
          r_row <= (w_row == LAST_ROW) ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
        if (w_emit) begin
          r_win_vld    <= 1'b1;
          r_cx         <= w_col - CW'(1);
          r_cy         <= w_row - RW'(1);
          r_frame_done <= w_last;
        end
      end
    end
  end

  assign bus.win_valid  = r_win_vld;
  assign bus.frame_done = r_frame_done;
  assign bus.cx         = r_cx;
  assign bus.cy         = r_cy;
  assign bus._1 = r_win[0];
  assign bus._2 = r_win[1];
  assign bus._3 = r_win[2];
  assign bus._4 = r_win[3];
  assign bus._5 = r_win[4];
  assign bus._6 = r_win[5];
  assign bus._7 = r_win[6];
  assign bus._8 = r_win[7];
  assign bus._9 = r_win[8];
endmodule
